imem_loader: RTL and testbench

Byte-stream writer for the processor's 256-byte instruction memory. Accepts a length-prefixed program from a host over a valid/ready byte handshake and stores bytes at consecutive addresses. Holds the processor core in reset until a complete, well-formed program is stored, then releases it. Sits beside `main`: drives its `instruction_mem` array and its `reset` input.

---
 rtl/imem_pkg.sv | 18 +
 rtl/imem_loader_if.sv | 12 +
 rtl/imem_loader.sv | 69 ++++++
 tb/tb_imem_loader.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// imem_pkg: shared types, sizes and the program-length validator for the instruction memory loader.
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } loader_state_t;

    localparam int IMEM_BYTES  = 256;
    localparam int IMEM_ADDR_W = 8;

    // Only whole 32-bit instructions that fit in memory are loadable.
    function automatic logic len_ok(input logic [8:0] len, input int unsigned mem_bytes);
        return (len != 9'd0) && (len[1:0] == 2'b00) && (32'(len) <= mem_bytes);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: host-side load control and valid/ready byte stream.
interface imem_loader_if;
    logic       load_start;
    logic [8:0] load_len;
    logic       load_abort;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_ready;

    modport master (output load_start, load_len, load_abort, byte_valid, byte_data, input byte_ready);
    modport slave  (input load_start, load_len, load_abort, byte_valid, byte_data, output byte_ready);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: streams a length-prefixed program into instruction memory and holds the core
// in reset until the whole program is resident.
module imem_loader
    import imem_pkg::*;
#(
    parameter int MEM_BYTES = IMEM_BYTES
) (
    input  logic                clk,
    input  logic                reset,
    imem_loader_if.slave        bus,
    output logic [7:0]          instruction_mem [MEM_BYTES],
    output logic                cpu_reset,
    output logic                load_done,
    output logic                load_error,
    output logic [7:0]          checksum
);
    localparam int AW = $clog2(MEM_BYTES);

    loader_state_t r_state, w_next;
    logic [8:0]    r_len, r_cnt;
    logic [7:0]    r_mem [MEM_BYTES];
    logic [7:0]    r_sum;
    logic          r_err, r_cpu_rst;
    logic          w_start, w_start_ok, w_xfer, w_last;

    assign w_start    = (r_state != LOAD) && bus.load_start;
    assign w_start_ok = w_start && len_ok(bus.load_len, MEM_BYTES);
    assign w_last     = (r_cnt + 9'd1) == r_len;

    always_comb begin
        bus.byte_ready = (r_state == LOAD) && !bus.load_abort;
        w_xfer = bus.byte_valid && bus.byte_ready;
        w_next = r_state;
        if (r_state == LOAD)
            w_next = bus.load_abort ? IDLE : (w_xfer && w_last) ? DONE : LOAD;
        else if (w_start)
            w_next = w_start_ok ? LOAD : IDLE;
        else if (r_state != DONE)
            w_next = IDLE;
    end

    // The core leaves reset only after a full cycle spent in DONE.
    always_ff @(posedge clk) begin
        r_state   <= reset ? IDLE : w_next;
        r_cpu_rst <= reset || !(r_state == DONE && w_next == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset || w_start_ok) begin
            for (int i = 0; i < MEM_BYTES; i++) r_mem[i] <= '0;
            r_cnt <= '0;
            r_sum <= '0;
            r_err <= 1'b0;
            r_len <= reset ? 9'd0 : bus.load_len;
        end else if (w_start || (r_state == LOAD && bus.load_abort)) begin
            r_err <= 1'b1;
        end else if (w_xfer) begin
            r_mem[r_cnt[AW-1:0]] <= bus.byte_data;
            r_cnt <= r_cnt + 9'd1;
            r_sum <= r_sum + bus.byte_data;
        end
    end

    assign instruction_mem = r_mem;
    assign cpu_reset       = r_cpu_rst;
    assign load_done       = r_state == DONE;
    assign load_error      = r_err;
    assign checksum        = r_sum;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scenario tasks against a cycle-level model built from the loader's rules.
module tb_imem_loader;
    import imem_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] imem [IMEM_BYTES];
    logic       cpu_reset, load_done, load_error;
    logic [7:0] checksum;

    imem_loader_if bus();

    imem_loader dut (
        .clk             (clk),
        .reset           (reset),
        .bus             (bus.slave),
        .instruction_mem (imem),
        .cpu_reset       (cpu_reset),
        .load_done       (load_done),
        .load_error      (load_error),
        .checksum        (checksum)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: 0 = idle, 1 = loading, 2 = program resident
    logic [7:0] m_mem [IMEM_BYTES];
    int         m_state, m_cnt, m_len, m_age, xfers;
    logic [7:0] m_sum;
    logic       m_err;

    function automatic int mem_diffs();
        int n = 0;
        for (int i = 0; i < IMEM_BYTES; i++) if (imem[i] !== m_mem[i]) n++;
        return n;
    endfunction

    function automatic logic exp_cpu_reset();
        return !(m_state == 2 && m_age >= 1);
    endfunction

    task automatic cycle(input bit rst, input bit st, input int len, input bit ab, input bit vl, input logic [7:0] d);
        reset = rst;
        bus.load_start = st;
        bus.load_len = 9'(len);
        bus.load_abort = ab;
        bus.byte_valid = vl;
        bus.byte_data = d;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < IMEM_BYTES; i++) m_mem[i] = 8'h00;
            m_state = 0; m_cnt = 0; m_sum = 8'h00; m_err = 1'b0; m_age = 0;
        end else if (m_state == 1) begin
            if (ab) begin
                m_state = 0; m_err = 1'b1;
            end else if (vl) begin
                m_mem[m_cnt] = d; m_cnt++; m_sum = m_sum + d; xfers++;
                if (m_cnt == m_len) begin m_state = 2; m_age = 0; end
            end
        end else if (st) begin
            if (len > 0 && len % 4 == 0 && len <= IMEM_BYTES) begin
                for (int i = 0; i < IMEM_BYTES; i++) m_mem[i] = 8'h00;
                m_cnt = 0; m_sum = 8'h00; m_err = 1'b0; m_len = len; m_state = 1;
            end else begin
                m_err = 1'b1; m_state = 0;
            end
        end else if (m_state == 2) begin
            m_age++;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 8'h00);
    endtask

    task automatic test_reset();
        cycle(1, 0, 0, 0, 0, 8'h00);
        cycle(1, 0, 0, 0, 0, 8'h00);
        checks += 6;
        if (cpu_reset !== 1'b1) begin errors++; $display("FAIL reset_cpu_reset: got %b want 1", cpu_reset); end
        if (load_done !== 1'b0) begin errors++; $display("FAIL reset_load_done: got %b want 0", load_done); end
        if (load_error !== 1'b0) begin errors++; $display("FAIL reset_load_error: got %b want 0", load_error); end
        if (checksum !== 8'h00) begin errors++; $display("FAIL reset_checksum: got %h want 00", checksum); end
        if (bus.byte_ready !== 1'b0) begin errors++; $display("FAIL reset_byte_ready: got %b want 0", bus.byte_ready); end
        if (mem_diffs() != 0) begin errors++; $display("FAIL reset_mem: %0d bytes differ want 0", mem_diffs()); end
        idle(1);
    endtask

    task automatic test_nominal();
        cycle(0, 1, 8, 0, 0, 8'h00);
        bus.load_start = 1'b0; bus.byte_valid = 1'b1; #1;
        checks++;
        if (bus.byte_ready !== 1'b1) begin errors++; $display("FAIL nom_ready: got %b want 1", bus.byte_ready); end
        for (int i = 1; i <= 8; i++) cycle(0, 0, 0, 0, 1, 8'(i));
        checks += 4;
        if (load_done !== 1'b1) begin errors++; $display("FAIL nom_done: got %b want 1", load_done); end
        if (cpu_reset !== 1'b1) begin errors++; $display("FAIL nom_cpu_rst_hold: got %b want 1", cpu_reset); end
        if (checksum !== 8'h24) begin errors++; $display("FAIL nom_checksum: got %h want 24", checksum); end
        if (mem_diffs() != 0 || imem[7] !== 8'h08 || imem[8] !== 8'h00)
            begin errors++; $display("FAIL nom_mem: %0d bytes differ, imem[7]=%h want 08", mem_diffs(), imem[7]); end
        idle(1);
        checks += 2;
        if (cpu_reset !== 1'b0) begin errors++; $display("FAIL nom_cpu_rst_fall: got %b want 0", cpu_reset); end
        if (bus.byte_ready !== 1'b0) begin errors++; $display("FAIL nom_done_ready: got %b want 0", bus.byte_ready); end
    endtask

    task automatic test_invalid_len();
        int lens [3] = '{0, 6, 260};
        for (int k = 0; k < 3; k++) begin
            cycle(0, 1, lens[k], 0, 0, 8'h00);
            idle(1);
            checks += 5;
            if (load_error !== 1'b1) begin errors++; $display("FAIL inv_err len=%0d: got %b want 1", lens[k], load_error); end
            if (cpu_reset !== 1'b1) begin errors++; $display("FAIL inv_cpu_rst len=%0d: got %b want 1", lens[k], cpu_reset); end
            if (load_done !== 1'b0) begin errors++; $display("FAIL inv_done len=%0d: got %b want 0", lens[k], load_done); end
            if (bus.byte_ready !== 1'b0) begin errors++; $display("FAIL inv_ready len=%0d: got %b want 0", lens[k], bus.byte_ready); end
            if (mem_diffs() != 0 || imem[0] !== 8'h01)
                begin errors++; $display("FAIL inv_mem len=%0d: %0d bytes differ want 0", lens[k], mem_diffs()); end
        end
    endtask

    task automatic test_bursty();
        bit         pat [7] = '{1, 0, 0, 1, 1, 0, 1};
        logic [7:0] dat [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        int         j = 0;
        int         x0;
        cycle(0, 1, 4, 0, 0, 8'h00);
        checks++;
        if (load_error !== 1'b0) begin errors++; $display("FAIL burst_err_clear: got %b want 0", load_error); end
        x0 = xfers;
        for (int i = 0; i < 7; i++) begin
            if (pat[i]) begin cycle(0, 0, 0, 0, 1, dat[j]); j++; end
            else cycle(0, 0, 0, 0, 0, 8'($urandom));
        end
        checks += 4;
        if (xfers - x0 != 4) begin errors++; $display("FAIL burst_xfers: got %0d want 4", xfers - x0); end
        if ({imem[0], imem[1], imem[2], imem[3]} !== 32'hAABBCCDD)
            begin errors++; $display("FAIL burst_mem: got %h%h%h%h want AABBCCDD", imem[0], imem[1], imem[2], imem[3]); end
        if (load_done !== 1'b1) begin errors++; $display("FAIL burst_done: got %b want 1", load_done); end
        if (checksum !== m_sum) begin errors++; $display("FAIL burst_checksum: got %h want %h", checksum, m_sum); end
        idle(2);
    endtask

    task automatic test_abort();
        cycle(0, 1, 8, 0, 0, 8'h00);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1, 8'($urandom_range(1, 255)));
        bus.load_abort = 1'b1; bus.byte_valid = 1'b1; #1;
        checks++;
        if (bus.byte_ready !== 1'b0) begin errors++; $display("FAIL abort_ready: got %b want 0", bus.byte_ready); end
        cycle(0, 0, 0, 1, 1, 8'h5A);
        checks += 6;
        if (imem[3] !== 8'h00) begin errors++; $display("FAIL abort_4th: got %h want 00", imem[3]); end
        if (mem_diffs() != 0) begin errors++; $display("FAIL abort_mem: %0d bytes differ want 0", mem_diffs()); end
        if (load_error !== 1'b1) begin errors++; $display("FAIL abort_err: got %b want 1", load_error); end
        if (load_done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b want 0", load_done); end
        if (cpu_reset !== 1'b1) begin errors++; $display("FAIL abort_cpu_rst: got %b want 1", cpu_reset); end
        if (checksum !== m_sum) begin errors++; $display("FAIL abort_checksum: got %h want %h", checksum, m_sum); end
        cycle(0, 0, 0, 1, 1, 8'h77);
        checks += 2;
        if (bus.byte_ready !== 1'b0) begin errors++; $display("FAIL abort_idle_ready: got %b want 0", bus.byte_ready); end
        if (load_error !== 1'b1) begin errors++; $display("FAIL abort_idle_err: got %b want 1", load_error); end
    endtask

    task automatic test_reload();
        int n = 4 * $urandom_range(4, 16);
        int budget = 0;
        cycle(0, 1, n, 0, 0, 8'h00);
        while (m_state == 1 && budget < 1000) begin
            cycle(0, 0, 0, 0, 1'($urandom_range(0, 1)), 8'($urandom));
            budget++;
        end
        idle(1);
        checks += 2;
        if (cpu_reset !== 1'b0) begin errors++; $display("FAIL reload_first_run: got %b want 0", cpu_reset); end
        if (mem_diffs() != 0) begin errors++; $display("FAIL reload_first_mem: %0d bytes differ want 0", mem_diffs()); end
        cycle(0, 1, 4, 0, 0, 8'h00);
        checks += 4;
        if (cpu_reset !== 1'b1) begin errors++; $display("FAIL reload_cpu_rst: got %b want 1", cpu_reset); end
        if (mem_diffs() != 0 || imem[5] !== 8'h00) begin errors++; $display("FAIL reload_zero: %0d bytes differ want 0", mem_diffs()); end
        if (checksum !== 8'h00) begin errors++; $display("FAIL reload_sum_clear: got %h want 00", checksum); end
        if (load_done !== 1'b0) begin errors++; $display("FAIL reload_done_clear: got %b want 0", load_done); end
        cycle(0, 0, 0, 0, 1, 8'h11);
        cycle(0, 1, 8, 0, 1, 8'h22);
        cycle(0, 0, 0, 0, 1, 8'h33);
        cycle(0, 0, 0, 0, 1, 8'h44);
        checks += 3;
        if (load_done !== 1'b1) begin errors++; $display("FAIL reload_done: got %b want 1 (start ignored in load)", load_done); end
        if ({imem[0], imem[1], imem[2], imem[3]} !== 32'h11223344 || mem_diffs() != 0)
            begin errors++; $display("FAIL reload_mem: got %h%h%h%h want 11223344", imem[0], imem[1], imem[2], imem[3]); end
        if (checksum !== 8'hAA) begin errors++; $display("FAIL reload_checksum: got %h want AA", checksum); end
        idle(1);
        checks++;
        if (cpu_reset !== 1'b0) begin errors++; $display("FAIL reload_cpu_rst_fall: got %b want 0", cpu_reset); end
    endtask

    task automatic test_reset_midload();
        cycle(0, 1, 16, 0, 0, 8'h00);
        cycle(0, 0, 0, 0, 1, 8'hF0);
        cycle(0, 0, 0, 0, 1, 8'h0F);
        cycle(1, 0, 0, 0, 1, 8'h99);
        bus.byte_valid = 1'b0; #1;
        checks += 5;
        if (mem_diffs() != 0 || imem[0] !== 8'h00) begin errors++; $display("FAIL rstmid_mem: %0d bytes differ want 0", mem_diffs()); end
        if (checksum !== 8'h00) begin errors++; $display("FAIL rstmid_checksum: got %h want 00", checksum); end
        if (bus.byte_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready: got %b want 0", bus.byte_ready); end
        if (cpu_reset !== 1'b1) begin errors++; $display("FAIL rstmid_cpu_rst: got %b want 1", cpu_reset); end
        if (load_done !== 1'b0 || load_error !== 1'b0)
            begin errors++; $display("FAIL rstmid_flags: done=%b err=%b want 0 0", load_done, load_error); end
        idle(1);
    endtask

    task automatic test_random();
        for (int t = 0; t < 12; t++) begin
            int len = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 300)) : 4 * int'($urandom_range(1, 64));
            int budget = 0;
            cycle(0, 1, len, 0, 0, 8'h00);
            while (m_state == 1 && budget < 2000) begin
                cycle(0, 1'($urandom_range(0, 9) == 0), int'($urandom_range(0, 511)),
                      1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 3) != 0), 8'($urandom));
                budget++;
            end
            checks += 6;
            if (m_state == 1) begin errors++; $display("FAIL rnd_timeout t=%0d: load still open after %0d cycles", t, budget); end
            if (mem_diffs() != 0) begin errors++; $display("FAIL rnd_mem t=%0d len=%0d: %0d bytes differ want 0", t, len, mem_diffs()); end
            if (checksum !== m_sum) begin errors++; $display("FAIL rnd_checksum t=%0d: got %h want %h", t, checksum, m_sum); end
            if (load_error !== m_err) begin errors++; $display("FAIL rnd_err t=%0d len=%0d: got %b want %b", t, len, load_error, m_err); end
            if (load_done !== (m_state == 2)) begin errors++; $display("FAIL rnd_done t=%0d: got %b want %b", t, load_done, m_state == 2); end
            if (cpu_reset !== exp_cpu_reset()) begin errors++; $display("FAIL rnd_cpu_rst t=%0d: got %b want %b", t, cpu_reset, exp_cpu_reset()); end
            idle(2);
            checks++;
            if (cpu_reset !== exp_cpu_reset()) begin errors++; $display("FAIL rnd_cpu_rst_late t=%0d: got %b want %b", t, cpu_reset, exp_cpu_reset()); end
        end
    endtask

    initial begin
        xfers = 0;
        test_reset();
        test_nominal();
        test_invalid_len();
        test_bursty();
        test_abort();
        test_reload();
        test_reset_midload();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
